// File: rtl/split_target_port_p.sv
// split_target_port_p: bit-serial target-side port for the split-transaction bus.
// Deserialises address / write-data bits into parallel words (with write-burst
// address increment) and serialises read data from a TX FIFO back onto the bus.
module split_target_port_p #(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned TX_DEPTH = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   // arbitration sideband
   input  logic                               split_req,
   input  logic                               arbiter_grant,
   output logic                               split_ack,
   output logic                               split_grant,
   output logic                               arbiter_split_req,
   // TX FIFO
   input  logic [DATA_W-1:0]                  tx_data,
   input  logic                               tx_valid,
   output logic                               tx_ready,
   output logic [$clog2(TX_DEPTH+1)-1:0]      tx_level,
   output logic                               tx_overflow,
   // target status pass-through
   input  logic                               target_rw,
   input  logic                               target_ready,
   input  logic                               target_split_ack,
   input  logic                               target_ack,
   output logic                               bus_target_rw,
   output logic                               bus_target_ready,
   output logic                               bus_split_ack,
   output logic                               bus_target_ack,
   // serial bus
   input  logic                               bus_data_in,
   input  logic                               bus_data_in_valid,
   input  logic                               bus_mode,
   output logic                               bus_data_out,
   output logic                               bus_data_out_valid,
   // parallel target side
   output logic [ADDR_W-1:0]                  target_addr_in,
   output logic                               target_addr_in_valid,
   output logic [DATA_W-1:0]                  target_data_in,
   output logic [ADDR_W-1:0]                  target_data_wr_addr,
   output logic                               target_data_in_valid
);

   localparam int unsigned LVL_W  = $clog2(TX_DEPTH + 1);
   localparam int unsigned PTR_W  = $clog2(TX_DEPTH);
   localparam int unsigned BCNT_W = $clog2(DATA_W + 1);
   localparam int unsigned AC_W   = $clog2(ADDR_W);
   localparam int unsigned DC_W   = $clog2(DATA_W);

   typedef enum logic {
      TX_IDLE  = 1'b0,
      TX_SHIFT = 1'b1
   } tx_state_t;

   // ---------------- sideband pass-through ----------------
   assign split_ack         = target_split_ack;
   assign split_grant       = arbiter_grant;
   assign arbiter_split_req = split_req;
   assign bus_target_rw     = target_rw;
   assign bus_target_ready  = target_ready;
   assign bus_split_ack     = target_split_ack;
   assign bus_target_ack    = target_ack;

   // ---------------- TX FIFO ----------------
   logic [DATA_W-1:0] mem [TX_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [LVL_W-1:0]  level;
   logic              full, empty, push, load;
   tx_state_t         tx_state;
   logic [DATA_W-1:0] shift_q;
   logic [BCNT_W-1:0] bit_cnt;

   assign full     = (level == LVL_W'(TX_DEPTH));
   assign empty    = (level == '0);
   assign push     = tx_valid & ~full;
   // a load (pop) happens from IDLE or on the edge that emits the last bit
   assign load     = ~empty & arbiter_grant &
                     ((tx_state == TX_IDLE) || (bit_cnt == BCNT_W'(1)));
   assign tx_ready = ~full;
   assign tx_level = level;

   // FIFO storage; contents need no reset since level gates every read
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= tx_data;
   end

   // FIFO pointers, occupancy and sticky overflow
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level       <= '0;
         tx_overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (load) rd_ptr <= rd_ptr + PTR_W'(1);
         level <= level + LVL_W'(push) - LVL_W'(load);
         if (tx_valid && full) tx_overflow <= 1'b1;
      end
   end

   // TX serializer: LSB first, reloads on the last bit for gapless words
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state           <= TX_IDLE;
         shift_q            <= '0;
         bit_cnt            <= '0;
         bus_data_out       <= 1'b0;
         bus_data_out_valid <= 1'b0;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               bus_data_out       <= 1'b0;
               bus_data_out_valid <= 1'b0;
               if (load) begin
                  shift_q  <= mem[rd_ptr];
                  bit_cnt  <= BCNT_W'(DATA_W);
                  tx_state <= TX_SHIFT;
               end
            end
            TX_SHIFT: begin
               bus_data_out       <= shift_q[0];
               bus_data_out_valid <= 1'b1;
               shift_q            <= shift_q >> 1;
               bit_cnt            <= bit_cnt - BCNT_W'(1);
               if (bit_cnt == BCNT_W'(1)) begin
                  if (load) begin
                     shift_q <= mem[rd_ptr];
                     bit_cnt <= BCNT_W'(DATA_W);
                  end else begin
                     tx_state <= TX_IDLE;
                  end
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   // ---------------- RX deserializer ----------------
   logic [ADDR_W-1:0] addr_sr, addr_full, base_addr, word_idx, word_addr_q;
   logic [DATA_W-1:0] data_sr, data_full, word_q;
   logic [AC_W-1:0]   addr_cnt;
   logic [DC_W-1:0]   data_cnt;
   logic              expect_data, addr_pending, data_pending;

   // shift registers with the incoming bit merged at the current position
   always_comb begin
      addr_full           = addr_sr;
      addr_full[addr_cnt] = bus_data_in;
      data_full           = data_sr;
      data_full[data_cnt] = bus_data_in;
   end

   // RX address/data capture, burst indexing and one-cycle output pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_sr              <= '0;
         data_sr              <= '0;
         addr_cnt             <= '0;
         data_cnt             <= '0;
         base_addr            <= '0;
         word_idx             <= '0;
         word_q               <= '0;
         word_addr_q          <= '0;
         expect_data          <= 1'b0;
         addr_pending         <= 1'b0;
         data_pending         <= 1'b0;
         target_addr_in       <= '0;
         target_addr_in_valid <= 1'b0;
         target_data_in       <= '0;
         target_data_wr_addr  <= '0;
         target_data_in_valid <= 1'b0;
      end else begin
         addr_pending         <= 1'b0;
         data_pending         <= 1'b0;
         target_addr_in_valid <= addr_pending;
         target_data_in_valid <= data_pending;
         if (addr_pending) target_addr_in <= base_addr;
         if (data_pending) begin
            target_data_in      <= word_q;
            target_data_wr_addr <= word_addr_q;
         end

         if (bus_data_in_valid) begin
            if (!bus_mode) begin
               addr_sr <= addr_full;
               if (addr_cnt == AC_W'(ADDR_W - 1)) begin
                  base_addr    <= addr_full;
                  word_idx     <= '0;
                  expect_data  <= target_rw;
                  addr_pending <= 1'b1;
                  addr_cnt     <= '0;
                  data_cnt     <= '0;
               end else begin
                  addr_cnt <= addr_cnt + AC_W'(1);
               end
            end else if (expect_data) begin
               if (addr_cnt != '0) begin
                  addr_cnt <= '0;
               end else begin
                  data_sr <= data_full;
                  if (data_cnt == DC_W'(DATA_W - 1)) begin
                     word_q       <= data_full;
                     word_addr_q  <= base_addr + word_idx;
                     word_idx     <= word_idx + ADDR_W'(1);
                     data_pending <= 1'b1;
                     data_cnt     <= '0;
                  end else begin
                     data_cnt <= data_cnt + DC_W'(1);
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_split_target_port_p.sv
// Scoreboard bench for split_target_port_p (default parameters).
module tb_split_target_port_p;

   logic        clk = 1'b0;
   logic        rst;
   logic        split_req, arbiter_grant;
   logic        split_ack, split_grant, arbiter_split_req;
   logic [7:0]  tx_data;
   logic        tx_valid, tx_ready;
   logic [2:0]  tx_level;
   logic        tx_overflow;
   logic        target_rw, target_ready, target_split_ack, target_ack;
   logic        bus_target_rw, bus_target_ready, bus_split_ack, bus_target_ack;
   logic        bus_data_in, bus_data_in_valid, bus_mode;
   logic        bus_data_out, bus_data_out_valid;
   logic [15:0] target_addr_in;
   logic        target_addr_in_valid;
   logic [7:0]  target_data_in;
   logic [15:0] target_data_wr_addr;
   logic        target_data_in_valid;

   int checks = 0;
   int errors = 0;

   logic        exp_bits  [$];
   int          exp_runs  [$];
   logic [15:0] exp_addr  [$];
   logic [23:0] exp_data  [$];
   int          run_len = 0;

   split_target_port_p dut (
      .clk(clk), .rst(rst),
      .split_req(split_req), .arbiter_grant(arbiter_grant),
      .split_ack(split_ack), .split_grant(split_grant),
      .arbiter_split_req(arbiter_split_req),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_level(tx_level), .tx_overflow(tx_overflow),
      .target_rw(target_rw), .target_ready(target_ready),
      .target_split_ack(target_split_ack), .target_ack(target_ack),
      .bus_target_rw(bus_target_rw), .bus_target_ready(bus_target_ready),
      .bus_split_ack(bus_split_ack), .bus_target_ack(bus_target_ack),
      .bus_data_in(bus_data_in), .bus_data_in_valid(bus_data_in_valid),
      .bus_mode(bus_mode),
      .bus_data_out(bus_data_out), .bus_data_out_valid(bus_data_out_valid),
      .target_addr_in(target_addr_in), .target_addr_in_valid(target_addr_in_valid),
      .target_data_in(target_data_in), .target_data_wr_addr(target_data_wr_addr),
      .target_data_in_valid(target_data_in_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic exp_word(input logic [7:0] w);
      for (int i = 0; i < 8; i++) exp_bits.push_back(w[i]);
   endtask

   task automatic push_word(input logic [7:0] w);
      @(negedge clk);
      tx_data  = w;
      tx_valid = 1'b1;
   endtask

   task automatic end_push();
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic send_bits(input logic [31:0] v, input int n, input logic mode);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus_data_in       = v[i];
         bus_data_in_valid = 1'b1;
         bus_mode          = mode;
      end
      @(negedge clk);
      bus_data_in_valid = 1'b0;
      bus_data_in       = 1'b0;
   endtask

   // monitor: compare every DUT output event against the scoreboard queues
   always @(negedge clk) begin
      if (!rst) begin
         if (bus_data_out_valid) begin
            run_len++;
            if (exp_bits.size() == 0) chk("tx_unexpected_bit", 32'(bus_data_out_valid), 32'd0);
            else chk("tx_bit", 32'(bus_data_out), 32'(exp_bits.pop_front()));
         end else if (run_len > 0) begin
            if (exp_runs.size() == 0) chk("tx_unexpected_run", 32'(run_len), 32'd0);
            else chk("tx_run_len", 32'(run_len), 32'(exp_runs.pop_front()));
            run_len = 0;
         end
         if (target_addr_in_valid) begin
            if (exp_addr.size() == 0) chk("rx_unexpected_addr", 32'(target_addr_in), 32'hDEAD);
            else chk("rx_addr", 32'(target_addr_in), 32'(exp_addr.pop_front()));
         end
         if (target_data_in_valid) begin
            if (exp_data.size() == 0)
               chk("rx_unexpected_data", 32'({target_data_wr_addr, target_data_in}), 32'hDEAD);
            else
               chk("rx_data", 32'({target_data_wr_addr, target_data_in}), 32'(exp_data.pop_front()));
         end
      end
   end

   initial begin
      rst = 1'b1; split_req = 0; arbiter_grant = 0; tx_data = 0; tx_valid = 0;
      target_rw = 0; target_ready = 0; target_split_ack = 0; target_ack = 0;
      bus_data_in = 0; bus_data_in_valid = 0; bus_mode = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_tx_ready", 32'(tx_ready), 32'd1);
      chk("rst_tx_level", 32'(tx_level), 32'd0);
      chk("rst_tx_overflow", 32'(tx_overflow), 32'd0);
      chk("rst_out_valid", 32'(bus_data_out_valid), 32'd0);
      chk("rst_outputs", 32'({target_addr_in_valid, target_data_in_valid, bus_data_out}), 32'd0);
      chk("rst_addr", 32'(target_addr_in), 32'd0);

      // sideband pass-through (grant kept low so TX stays quiet)
      split_req = 1; target_rw = 1; target_ready = 0; target_split_ack = 1; target_ack = 0;
      #1;
      chk("sideband_a", 32'({arbiter_split_req, split_grant, split_ack, bus_target_rw,
                             bus_target_ready, bus_split_ack, bus_target_ack}), 32'b1011010);
      split_req = 0; target_rw = 0; target_ready = 1; target_split_ack = 0; target_ack = 1;
      #1;
      chk("sideband_b", 32'({arbiter_split_req, split_grant, split_ack, bus_target_rw,
                             bus_target_ready, bus_split_ack, bus_target_ack}), 32'b0000101);
      target_ready = 0; target_ack = 0;

      // single word 0xA5: first bit two edges after the push edge
      exp_word(8'hA5); exp_runs.push_back(8);
      arbiter_grant = 1;
      push_word(8'hA5);
      end_push();
      chk("a5_valid_push_edge", 32'(bus_data_out_valid), 32'd0);
      @(negedge clk);
      chk("a5_valid_load_edge", 32'(bus_data_out_valid), 32'd0);
      @(negedge clk);
      chk("a5_valid_first_bit", 32'(bus_data_out_valid), 32'd1);
      repeat (15) @(negedge clk);

      // back-to-back 0x3C, 0xF0: one 16-bit run
      exp_word(8'h3C); exp_word(8'hF0); exp_runs.push_back(16);
      push_word(8'h3C);
      push_word(8'hF0);
      end_push();
      repeat (24) @(negedge clk);

      // overflow: five pushes with no grant, only four accepted and sent
      arbiter_grant = 0;
      for (int i = 1; i <= 4; i++) exp_word(8'(i * 8'h11));
      exp_runs.push_back(32);
      for (int i = 1; i <= 5; i++) push_word(8'(i * 8'h11));
      end_push();
      chk("ovf_level", 32'(tx_level), 32'd4);
      chk("ovf_ready", 32'(tx_ready), 32'd0);
      chk("ovf_flag", 32'(tx_overflow), 32'd1);
      arbiter_grant = 1;
      repeat (40) @(negedge clk);
      chk("ovf_sticky", 32'(tx_overflow), 32'd1);
      chk("drain_level", 32'(tx_level), 32'd0);
      arbiter_grant = 0;

      // write burst of three words at 0x1234
      target_rw = 1;
      exp_addr.push_back(16'h1234);
      exp_data.push_back({16'h1234, 8'h11});
      exp_data.push_back({16'h1235, 8'h22});
      exp_data.push_back({16'h1236, 8'h33});
      send_bits(32'h1234, 16, 1'b0);
      send_bits(32'h332211, 24, 1'b1);
      repeat (4) @(negedge clk);

      // burst wraps the address space
      exp_addr.push_back(16'hFFFF);
      exp_data.push_back({16'hFFFF, 8'hBB});
      exp_data.push_back({16'h0000, 8'hAA});
      send_bits(32'hFFFF, 16, 1'b0);
      send_bits(32'hAABB, 16, 1'b1);
      repeat (4) @(negedge clk);

      // reset mid data word: no pulse, then a fresh address is received
      exp_addr.push_back(16'hC3A5);
      send_bits(32'h0, 16, 1'b0);
      exp_addr.pop_back();
      exp_addr.push_back(16'h0000);
      exp_addr.push_back(16'hC3A5);
      repeat (4) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus_data_in = 1'b1; bus_data_in_valid = 1'b1; bus_mode = 1'b1;
      end
      @(negedge clk);
      bus_data_in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst2_overflow", 32'(tx_overflow), 32'd0);
      chk("rst2_data_valid", 32'(target_data_in_valid), 32'd0);
      target_rw = 0;
      send_bits(32'hC3A5, 16, 1'b0);
      // expect_data is 0 now: these data bits must be ignored
      send_bits(32'h5A, 8, 1'b1);
      repeat (10) @(negedge clk);

      chk("q_bits_empty", 32'(exp_bits.size()), 32'd0);
      chk("q_runs_empty", 32'(exp_runs.size()), 32'd0);
      chk("q_addr_empty", 32'(exp_addr.size()), 32'd0);
      chk("q_data_empty", 32'(exp_data.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: timeout reached");
      $fatal(1);
   end

endmodule
